// File: rtl/gemm_seq_pkg.sv
// Shared types and default widths for the GEMM tile-loop sequencer.
// Optional stall counter is enabled with GEMM_STALL_CNT_EN.
package gemm_seq_pkg;

  localparam int unsigned TILE_W          = 8;
  localparam int unsigned TILE_ROWS       = 32;
  localparam int unsigned TILE_COLS       = 32;
  localparam int unsigned URAM_ADDR_WIDTH = 12;
  localparam int unsigned OP_ADDR_WIDTH   = 15;
  localparam int unsigned NUM_MAT_WIDTH   = 5;
  localparam int unsigned CNT_WIDTH       = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT_T = 3'd2,
    WB     = 3'd3,
    WAIT_W = 3'd4,
    FINISH = 3'd5
  } state_t;

  typedef struct packed {
    logic [TILE_W-1:0]        m;
    logic [TILE_W-1:0]        n;
    logic [TILE_W-1:0]        k;
    logic [NUM_MAT_WIDTH-1:0] num_mats;
  } cfg_t;

  function automatic logic cfg_has_zero(input cfg_t c);
    return (c.m == '0) || (c.n == '0) || (c.k == '0) || (c.num_mats == '0);
  endfunction

endpackage

// File: rtl/gemm_seq_addr_gen.sv
// Multiplier-free stride accumulators for the A, B and C tile base addresses.
module gemm_seq_addr_gen #(
  parameter int unsigned AW       = 12,
  parameter int unsigned CW       = 15,
  parameter int unsigned A_STRIDE = 32,
  parameter int unsigned B_STRIDE = 32,
  parameter int unsigned C_STRIDE = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_restart,
  input  logic          i_step_k,
  input  logic          i_step_n,
  input  logic          i_step_m,
  output logic [AW-1:0] o_a_base,
  output logic [AW-1:0] o_b_base,
  output logic [CW-1:0] o_c_base
);

  localparam logic [AW-1:0] A_INC = AW'(A_STRIDE);
  localparam logic [AW-1:0] B_INC = AW'(B_STRIDE);
  localparam logic [CW-1:0] C_INC = CW'(C_STRIDE);

  logic [AW-1:0] r_a;
  logic [AW-1:0] r_a_row;
  logic [AW-1:0] r_b;
  logic [CW-1:0] r_c;

  // At the last ki, a+stride and b+stride already land on the next row/col start.
  always_ff @(posedge clk) begin
    if (reset || i_restart) begin
      r_a     <= '0;
      r_a_row <= '0;
      r_b     <= '0;
      r_c     <= '0;
    end else if (i_step_k) begin
      r_a <= r_a + A_INC;
      r_b <= r_b + B_INC;
    end else if (i_step_n) begin
      r_a <= r_a_row;
      r_b <= r_b + B_INC;
      r_c <= r_c + C_INC;
    end else if (i_step_m) begin
      r_a     <= r_a + A_INC;
      r_a_row <= r_a + A_INC;
      r_b     <= '0;
      r_c     <= r_c + C_INC;
    end
  end

  assign o_a_base = r_a;
  assign o_b_base = r_b;
  assign o_c_base = r_c;

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Tile-loop controller for batched GEMM: issues tile computes and write-backs.
// Define GEMM_STALL_CNT_EN to build the wait-stall cycle counter.
module gemm_tile_sequencer
  import gemm_seq_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [TILE_W-1:0]          cfg_m_tiles,
  input  logic [TILE_W-1:0]          cfg_n_tiles,
  input  logic [TILE_W-1:0]          cfg_k_tiles,
  input  logic [NUM_MAT_WIDTH-1:0]   cfg_num_mats,
  output logic                       tile_start,
  output logic                       accum_clear,
  output logic [URAM_ADDR_WIDTH-1:0] a_base,
  output logic [URAM_ADDR_WIDTH-1:0] b_base,
  input  logic                       tile_done,
  output logic                       wb_start,
  output logic [OP_ADDR_WIDTH-1:0]   c_base,
  input  logic                       wb_done,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_MAT_WIDTH-1:0]   num_mat_done,
  output logic [CNT_WIDTH-1:0]       active_clk_count,
  output logic [CNT_WIDTH-1:0]       stall_clk_count
);

  state_t                   r_state;
  cfg_t                     r_cfg;
  logic [TILE_W-1:0]        r_mi;
  logic [TILE_W-1:0]        r_ni;
  logic [TILE_W-1:0]        r_ki;
  logic [NUM_MAT_WIDTH-1:0] r_mat;
  logic [NUM_MAT_WIDTH-1:0] r_nmd;
  logic [CNT_WIDTH-1:0]     r_active;
  logic                     r_tile_start;
  logic                     r_accum_clear;
  logic                     r_wb_start;
  logic                     r_busy;
  logic                     r_done;

  cfg_t w_cfg_in;
  logic w_accept;
  logic w_last_k;
  logic w_last_n;
  logic w_last_m;
  logic w_last_mat;
  logic w_adv;
  logic w_step_k;
  logic w_step_n;
  logic w_step_m;
  logic w_restart;

  assign w_cfg_in   = '{m: cfg_m_tiles, n: cfg_n_tiles, k: cfg_k_tiles, num_mats: cfg_num_mats};
  assign w_accept   = (r_state == IDLE) && start;
  assign w_last_k   = (r_ki == r_cfg.k - TILE_W'(1));
  assign w_last_n   = (r_ni == r_cfg.n - TILE_W'(1));
  assign w_last_m   = (r_mi == r_cfg.m - TILE_W'(1));
  assign w_last_mat = (r_mat == r_cfg.num_mats - NUM_MAT_WIDTH'(1));
  assign w_adv      = (r_state == WAIT_W) && wb_done && !abort;
  assign w_step_k   = (r_state == WAIT_T) && tile_done && !abort && !w_last_k;
  assign w_step_n   = w_adv && !w_last_n;
  assign w_step_m   = w_adv && w_last_n && !w_last_m;
  assign w_restart  = w_accept || (w_adv && w_last_n && w_last_m);

  // The start-acceptance cycle counts as the first active cycle of a run.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cfg         <= '0;
      r_mi          <= '0;
      r_ni          <= '0;
      r_ki          <= '0;
      r_mat         <= '0;
      r_nmd         <= '0;
      r_active      <= '0;
      r_tile_start  <= 1'b0;
      r_accum_clear <= 1'b0;
      r_wb_start    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_tile_start  <= 1'b0;
      r_accum_clear <= 1'b0;
      r_wb_start    <= 1'b0;
      r_done        <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          r_cfg         <= w_cfg_in;
          r_mi          <= '0;
          r_ni          <= '0;
          r_ki          <= '0;
          r_mat         <= '0;
          r_nmd         <= '0;
          r_active      <= CNT_WIDTH'(1);
          r_state       <= ISSUE;
          r_busy        <= 1'b1;
          r_tile_start  <= !cfg_has_zero(w_cfg_in);
          r_accum_clear <= !cfg_has_zero(w_cfg_in);
        end
      end else if (abort) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        r_active <= r_active + CNT_WIDTH'(1);
        case (r_state)
          ISSUE: begin
            if (cfg_has_zero(r_cfg)) begin
              r_state <= FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state <= WAIT_T;
            end
          end
          WAIT_T: begin
            if (tile_done) begin
              if (!w_last_k) begin
                r_ki         <= r_ki + TILE_W'(1);
                r_state      <= ISSUE;
                r_tile_start <= 1'b1;
              end else begin
                r_state    <= WB;
                r_wb_start <= 1'b1;
              end
            end
          end
          WB: r_state <= WAIT_W;
          WAIT_W: begin
            if (wb_done) begin
              r_ki          <= '0;
              r_state       <= ISSUE;
              r_tile_start  <= 1'b1;
              r_accum_clear <= 1'b1;
              if (!w_last_n) begin
                r_ni <= r_ni + TILE_W'(1);
              end else begin
                r_ni <= '0;
                if (!w_last_m) begin
                  r_mi <= r_mi + TILE_W'(1);
                end else begin
                  r_mi <= '0;
                  if (r_nmd != '1) r_nmd <= r_nmd + NUM_MAT_WIDTH'(1);
                  if (!w_last_mat) begin
                    r_mat <= r_mat + NUM_MAT_WIDTH'(1);
                  end else begin
                    r_mat         <= '0;
                    r_state       <= FINISH;
                    r_done        <= 1'b1;
                    r_tile_start  <= 1'b0;
                    r_accum_clear <= 1'b0;
                  end
                end
              end
            end
          end
          FINISH: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  gemm_seq_addr_gen #(
    .AW       (URAM_ADDR_WIDTH),
    .CW       (OP_ADDR_WIDTH),
    .A_STRIDE (TILE_ROWS),
    .B_STRIDE (TILE_COLS),
    .C_STRIDE (TILE_ROWS)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .i_restart (w_restart),
    .i_step_k  (w_step_k),
    .i_step_n  (w_step_n),
    .i_step_m  (w_step_m),
    .o_a_base  (a_base),
    .o_b_base  (b_base),
    .o_c_base  (c_base)
  );

`ifdef GEMM_STALL_CNT_EN
  logic                 r_wait_cont;
  logic [CNT_WIDTH-1:0] r_stall;
  logic                 w_in_wait;
  logic                 w_leave;

  assign w_in_wait = (r_state == WAIT_T) || (r_state == WAIT_W);
  assign w_leave   = ((r_state == WAIT_T) && tile_done) || ((r_state == WAIT_W) && wb_done);

  // r_wait_cont marks that the current wait cycle is not the first of its wait.
  always_ff @(posedge clk) begin
    if (reset || w_accept) begin
      r_stall     <= '0;
      r_wait_cont <= 1'b0;
    end else if (abort) begin
      r_wait_cont <= 1'b0;
    end else if (w_in_wait) begin
      if (r_wait_cont && (r_stall != '1)) r_stall <= r_stall + CNT_WIDTH'(1);
      r_wait_cont <= !w_leave;
    end else begin
      r_wait_cont <= 1'b0;
    end
  end

  assign stall_clk_count = r_stall;
`else
  assign stall_clk_count = '0;
`endif

  assign tile_start       = r_tile_start;
  assign accum_clear      = r_accum_clear;
  assign wb_start         = r_wb_start;
  assign busy             = r_busy;
  assign done             = r_done;
  assign num_mat_done     = r_nmd;
  assign active_clk_count = r_active;

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Self-checking bench for gemm_tile_sequencer: table of runs plus abort/restart corner sequences.
module tb_gemm_tile_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  cfg_m_tiles;
  logic [7:0]  cfg_n_tiles;
  logic [7:0]  cfg_k_tiles;
  logic [4:0]  cfg_num_mats;
  logic        tile_start;
  logic        accum_clear;
  logic [11:0] a_base;
  logic [11:0] b_base;
  logic        tile_done;
  logic        wb_start;
  logic [14:0] c_base;
  logic        wb_done;
  logic        busy;
  logic        done;
  logic [4:0]  num_mat_done;
  logic [31:0] active_clk_count;
  logic [31:0] stall_clk_count;

  always #5 clk = ~clk;

  gemm_tile_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
    .cfg_m_tiles      (cfg_m_tiles),
    .cfg_n_tiles      (cfg_n_tiles),
    .cfg_k_tiles      (cfg_k_tiles),
    .cfg_num_mats     (cfg_num_mats),
    .tile_start       (tile_start),
    .accum_clear      (accum_clear),
    .a_base           (a_base),
    .b_base           (b_base),
    .tile_done        (tile_done),
    .wb_start         (wb_start),
    .c_base           (c_base),
    .wb_done          (wb_done),
    .busy             (busy),
    .done             (done),
    .num_mat_done     (num_mat_done),
    .active_clk_count (active_clk_count),
    .stall_clk_count  (stall_clk_count)
  );

  typedef struct {
    int m, n, k, mats, dt, dw;
    int exp_nmd, exp_act, exp_stall;
  } vec_t;

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic        clr;
  } texp_t;

  texp_t       tq[$];
  logic [14:0] cq[$];
  vec_t        tbl[8];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_ts, n_wb, n_done, done_cyc, s_cyc;
  int cur_dt = 1, cur_dw = 1, td_cnt = 0, wd_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int stall_exp(input vec_t v);
`ifdef GEMM_STALL_CNT_EN
    return v.exp_stall;
`else
    return 0;
`endif
  endfunction

  // Reference address model uses direct products, reduced modulo the port widths.
  task automatic push_expect(input vec_t v);
    texp_t e;
    if (v.m == 0 || v.n == 0 || v.k == 0 || v.mats == 0) return;
    for (int mat = 0; mat < v.mats; mat++)
      for (int mi = 0; mi < v.m; mi++)
        for (int ni = 0; ni < v.n; ni++) begin
          for (int ki = 0; ki < v.k; ki++) begin
            e.a   = 12'(((mi * v.k + ki) * 32) % 4096);
            e.b   = 12'(((ni * v.k + ki) * 32) % 4096);
            e.clr = (ki == 0);
            tq.push_back(e);
          end
          cq.push_back(15'(((mi * v.n + ni) * 32) % 32768));
        end
  endtask

  // Monitor + responder: scoreboard pops on each pulse, done strobes answered after dt/dw cycles.
  initial begin
    texp_t e;
    tile_done = 1'b0;
    wb_done   = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      tile_done = 1'b0;
      wb_done   = 1'b0;
      if (td_cnt > 0) begin
        td_cnt--;
        if (td_cnt == 0) tile_done = 1'b1;
      end
      if (wd_cnt > 0) begin
        wd_cnt--;
        if (wd_cnt == 0) wb_done = 1'b1;
      end
      if (tile_start) begin
        n_ts++;
        if (tq.size() == 0) begin
          chk("unexpected_tile_start", 32'(1), 32'(0));
        end else begin
          e = tq.pop_front();
          chk("a_base", 32'(a_base), 32'(e.a));
          chk("b_base", 32'(b_base), 32'(e.b));
          chk("accum_clear", 32'(accum_clear), 32'(e.clr));
        end
        td_cnt = cur_dt;
      end
      if (wb_start) begin
        n_wb++;
        if (cq.size() == 0) chk("unexpected_wb_start", 32'(1), 32'(0));
        else chk("c_base", 32'(c_base), 32'(cq.pop_front()));
        wd_cnt = cur_dw;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  task automatic begin_case(input vec_t v, input logic ab);
    cfg_m_tiles  = 8'(v.m);
    cfg_n_tiles  = 8'(v.n);
    cfg_k_tiles  = 8'(v.k);
    cfg_num_mats = 5'(v.mats);
    cur_dt = v.dt;
    cur_dw = v.dw;
    n_ts = 0; n_wb = 0; n_done = 0;
    push_expect(v);
    @(posedge clk); #1;
    start = 1'b1;
    abort = ab;
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic finish_case(input vec_t v);
    int zero;
    zero = (v.m == 0 || v.n == 0 || v.k == 0 || v.mats == 0);
    for (int i = 0; i < 4000 && n_done == 0; i++) @(negedge clk);
    if (n_done == 0) begin
      chk("done_timeout", 32'(0), 32'(1));
      tq.delete();
      cq.delete();
    end
    @(negedge clk);
    chk("done_latency", 32'(done_cyc - s_cyc), 32'(v.exp_act - 1));
    chk("done_count", 32'(n_done), 32'(1));
    chk("busy_after", 32'(busy), 32'(0));
    chk("num_mat_done", 32'(num_mat_done), 32'(v.exp_nmd));
    chk("active_clk_count", active_clk_count, 32'(v.exp_act));
    chk("stall_clk_count", stall_clk_count, 32'(stall_exp(v)));
    chk("tile_start_count", 32'(n_ts), zero ? 32'(0) : 32'(v.mats * v.m * v.n * v.k));
    chk("wb_start_count", 32'(n_wb), zero ? 32'(0) : 32'(v.mats * v.m * v.n));
    chk("tile_queue_left", 32'(tq.size()), 32'(0));
    chk("wb_queue_left", 32'(cq.size()), 32'(0));
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_tile_start"}, 32'(tile_start), 32'(0));
    chk({tag, "_accum_clear"}, 32'(accum_clear), 32'(0));
    chk({tag, "_wb_start"}, 32'(wb_start), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_a_base"}, 32'(a_base), 32'(0));
    chk({tag, "_b_base"}, 32'(b_base), 32'(0));
    chk({tag, "_c_base"}, 32'(c_base), 32'(0));
    chk({tag, "_num_mat_done"}, 32'(num_mat_done), 32'(0));
    chk({tag, "_active"}, active_clk_count, 32'(0));
    chk({tag, "_stall"}, stall_clk_count, 32'(0));
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_m_tiles = '0; cfg_n_tiles = '0; cfg_k_tiles = '0; cfg_num_mats = '0;
    //            m  n  k  mats dt dw nmd act stall
    tbl[0] = '{1, 1, 1,  1, 1, 1,  1,   6,  0};
    tbl[1] = '{2, 2, 2,  1, 1, 1,  1,  26,  0};
    tbl[2] = '{3, 2, 0,  1, 1, 1,  0,   3,  0};
    tbl[3] = '{1, 1, 1, 31, 1, 1, 31, 126,  0};
    tbl[4] = '{1, 1, 1,  1, 5, 1,  1,  10,  4};
    tbl[5] = '{3, 2, 2,  2, 2, 3,  2, 122, 48};
    tbl[6] = '{0, 1, 1,  1, 1, 1,  0,   3,  0};
    tbl[7] = '{5, 1, 30, 1, 1, 1,  1, 312,  0};

    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      begin_case(tbl[i], 1'b0);
      finish_case(tbl[i]);
    end

    // Abort in the third WAIT_T of the 2x2x2 run.
    v = '{2, 2, 2, 1, 4, 1, 0, 0, 0};
    begin_case(v, 1'b0);
    for (int i = 0; i < 200 && n_ts < 3; i++) @(negedge clk);
    chk("abort_reach_tile3", 32'(n_ts), 32'(3));
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy_drop", 32'(busy), 32'(0));
    chk("abort_active", active_clk_count, 32'(14));
    repeat (8) @(negedge clk);
    chk("abort_active_frozen", active_clk_count, 32'(14));
`ifdef GEMM_STALL_CNT_EN
    chk("abort_stall_frozen", stall_clk_count, 32'(6));
`else
    chk("abort_stall_frozen", stall_clk_count, 32'(0));
`endif
    chk("abort_no_done", 32'(n_done), 32'(0));
    chk("abort_tile_starts", 32'(n_ts), 32'(3));
    chk("abort_wb_starts", 32'(n_wb), 32'(1));
    tq.delete();
    cq.delete();
    begin_case(tbl[1], 1'b0);
    finish_case(tbl[1]);

    // Start with changed cfg while busy is ignored.
    v = '{1, 1, 2, 1, 3, 1, 1, 12, 4};
    begin_case(v, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    cfg_m_tiles = 8'd2; cfg_n_tiles = 8'd2; cfg_k_tiles = 8'd2; cfg_num_mats = 5'd3;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    finish_case(v);

    // Reset in the middle of a run.
    begin_case(tbl[1], 1'b0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_zero_outputs("midreset");
    reset = 1'b0;
    tq.delete();
    cq.delete();
    td_cnt = 0;
    wd_cnt = 0;
    n_ts = 0;
    repeat (6) @(negedge clk);
    chk("midreset_idle_busy", 32'(busy), 32'(0));
    chk("midreset_no_tiles", 32'(n_ts), 32'(0));

    // Abort while idle has no effect; abort together with start lets start win.
    @(posedge clk); #1;
    abort = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'(0));
    chk("idle_abort_active", active_clk_count, 32'(0));
    begin_case(tbl[0], 1'b1);
    finish_case(tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/gemm_tile_sequencer.md
Name: gemm_tile_sequencer

Overview:
Single-clock tile-loop controller for large-matrix GEMM: C = A x B, with A of size M_t x K_t tiles, B of size K_t x N_t tiles, C of size M_t x N_t tiles.
- Replaces the fixed M_LARGE/N_LARGE sweep with run-time tile counts and a multi-matrix batch count.
- Generates row/col URAM tile base addresses and output-URAM write-back base addresses.
- Handshakes compute and write-back with the DSP cascade core.
- Sits between the synchronizer (clk domain) and gemm_top's compute/write-back engines.

Parameters:
- TILE_W, 8, width of each cfg tile-count field.
- TILE_ROWS, 32, rows per A/C tile; A and C address stride per tile.
- TILE_COLS, 32, cols per B tile; B address stride per tile.
- URAM_ADDR_WIDTH, 12, row/col URAM address width.
- OP_ADDR_WIDTH, 15, output URAM address width.
- NUM_MAT_WIDTH, 5, batch count and num_mat_done width.
- CNT_WIDTH, 32, cycle counter width.

Ports:
- clk  in  1  kernel clock.
- reset  in  1  synchronous, active-high.
- start  in  1  start pulse, level-tolerant; accepted only in IDLE.
- abort  in  1  synchronous soft abort.
- cfg_m_tiles  in  TILE_W  M_t.
- cfg_n_tiles  in  TILE_W  N_t.
- cfg_k_tiles  in  TILE_W  K_t.
- cfg_num_mats  in  NUM_MAT_WIDTH  matrices per batch.
- tile_start  out  1  one-cycle pulse: compute one A x B tile product.
- accum_clear  out  1  asserted with tile_start when ki==0.
- a_base  out  URAM_ADDR_WIDTH  A tile base address.
- b_base  out  URAM_ADDR_WIDTH  B tile base address.
- tile_done  in  1  compute finished pulse.
- wb_start  out  1  one-cycle pulse: write accumulated C tile to output URAM.
- c_base  out  OP_ADDR_WIDTH  C tile base address.
- wb_done  in  1  write-back finished pulse.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at batch completion.
- num_mat_done  out  NUM_MAT_WIDTH  completed matrices.
- active_clk_count  out  CNT_WIDTH  busy cycles of the last or current run.
- stall_clk_count  out  CNT_WIDTH  see Optional Feature.

Behaviour:
Reset: all outputs 0, state IDLE.

Configuration and start:
- start in IDLE latches all cfg_* fields. Changes to cfg_* while busy have no effect.
- The accepted start clears num_mat_done, active_clk_count and stall_clk_count, and sets loop indices mat=mi=ni=ki=0.
- If any latched cfg field is 0: go directly to FINISH, so done pulses 2 cycles after start with num_mat_done=0.

States:
- IDLE.
- ISSUE: pulse tile_start; a_base and b_base are valid in this cycle and held until the next ISSUE.
- WAIT_T.
- WB: pulse wb_start; c_base valid and held.
- WAIT_W.
- FINISH: pulse done, then IDLE.

Transitions:
- ISSUE -> WAIT_T.
- WAIT_T on tile_done: ki<K_t-1 -> ki++ then ISSUE; else -> WB.
- WB -> WAIT_W.
- WAIT_W on wb_done: ki=0, then advance ni (inner), then mi, then mat (outer).
  - On wrapping past the last mi: num_mat_done++ (saturates at 2^NUM_MAT_WIDTH-1).
  - On wrapping past the last mat: FINISH; otherwise ISSUE.

Addressing (no multipliers; running accumulators, truncated modulo 2^width):
- a_base = (mi*K_t+ki)*TILE_ROWS.
- b_base = (ni*K_t+ki)*TILE_COLS.
- c_base = (mi*N_t+ni)*TILE_ROWS.
- All three restart at 0 for each new mat.

Handshake rules:
- tile_done/wb_done are accepted only in WAIT_T/WAIT_W; ignored elsewhere.
- tile_done may arrive the cycle after tile_start; minimum tile period is 2 cycles.

Counters:
- active_clk_count increments every cycle busy=1, including the FINISH cycle, and holds in IDLE.

Abort and reset:
- abort in any non-IDLE state -> IDLE next cycle. No done pulse. Counters hold. No further tile_start or wb_start.
- abort in IDLE: no effect.
- abort together with start in IDLE: start wins.
- reset mid-run: same as the power-on reset values.

Optional Feature:
Macro GEMM_STALL_CNT_EN.
- Defined: stall_clk_count increments every cycle spent in WAIT_T or WAIT_W beyond the first cycle of each wait. It saturates at all-ones.
- Undefined: stall_clk_count is tied to 0 and no counter logic is synthesized.

Decomposition:
- Package gemm_seq_pkg: state enum (IDLE, ISSUE, WAIT_T, WB, WAIT_W, FINISH), default width localparams, and a cfg struct holding m/n/k/num_mats.
- One sub-module, gemm_seq_addr_gen: the stride accumulators for a_base, b_base and c_base, driven by step_k, step_n, step_m and restart strobes from the FSM.

Test Plan:
1. cfg M=N=K=1, mats=1; respond to tile_done and wb_done 1 cycle later. Expect: 1 tile_start with accum_clear=1, a=b=c=0; 1 wb_start; done at cycle 6; num_mat_done=1; active_clk_count=6.
2. cfg M=N=K=2, mats=1.
   - Expect 8 tile_starts, (a,b) = (0,0),(32,32),(0,64),(32,96),(64,0),(96,32),(64,64),(96,96).
   - accum_clear on every other tile_start.
   - c_base = 0,32,64,96.
3. cfg K=0, any other values: done pulses 2 cycles after start, with no tile_start and no wb_start.
4. abort during the 3rd WAIT_T of case 2: busy drops next cycle, done is never asserted, and counters freeze. A new start then runs case 2 cleanly from a=b=0.
5. start pulsed while busy, with cfg changed: ignored, and the original cfg completes. Also mats=31 with M=N=K=1: num_mat_done reaches 31.
6. GEMM_STALL_CNT_EN defined, case 1 with tile_done delayed 5 cycles: stall_clk_count=4. With the macro undefined: stall_clk_count stays 0.
